// File: rtl/axis_xform_pipe.sv
// AXI4-Stream transform pipeline: per-packet mode selected at the first beat, transform in stage 0,
// elastic bubble-collapsing delay stages behind it, plus occupancy and beat/packet counters.
module axis_xform_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int STAGES      = 2,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            aresetn,
  input  logic [1:0]                      mode,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [$clog2(STAGES+1)-1:0]     occupancy,
  output logic [COUNT_WIDTH-1:0]          in_beats,
  output logic [COUNT_WIDTH-1:0]          out_beats,
  output logic [COUNT_WIDTH-1:0]          out_packets
);

  localparam int HALF  = DATA_WIDTH / 2;
  localparam int OCC_W = $clog2(STAGES + 1);

  // Low half is zero-extended first so the square fits DATA_WIDTH exactly.
  function automatic logic [DATA_WIDTH-1:0] xform(input logic [1:0] m,
                                                  input logic [DATA_WIDTH-1:0] d);
    logic [DATA_WIDTH-1:0] lo;
    lo = {{(DATA_WIDTH-HALF){1'b0}}, d[HALF-1:0]};
    case (m)
      2'd0:    xform = d;
      2'd1:    xform = ~d;
      2'd2:    xform = lo * lo;
      2'd3:    xform = ~d + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      default: xform = d;
    endcase
  endfunction

  logic [STAGES-1:0]     valid_q;
  logic [STAGES-1:0]     last_q;
  logic [DATA_WIDTH-1:0] data_q [STAGES];
  logic                  in_packet_q;
  logic [1:0]            pkt_mode_q;
  logic [OCC_W-1:0]      occ_q;
  logic [COUNT_WIDTH-1:0] in_beats_q;
  logic [COUNT_WIDTH-1:0] out_beats_q;
  logic [COUNT_WIDTH-1:0] out_packets_q;

  logic [STAGES-1:0]     adv_s;
  logic                  accept_s;
  logic                  deliver_s;
  logic [1:0]            eff_mode_s;
  logic [DATA_WIDTH-1:0] xform_s;

  // Stage i may advance if any stage at or after it is empty, or the sink is ready.
  always_comb begin : ready_chain
    logic run_s;
    run_s = m_axis_tready;
    adv_s = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      run_s    = run_s | ~valid_q[i];
      adv_s[i] = run_s;
    end
  end

  assign s_axis_tready = aresetn & adv_s[0];
  assign accept_s      = s_axis_tvalid & s_axis_tready;
  assign deliver_s     = valid_q[STAGES-1] & m_axis_tready;
  assign eff_mode_s    = in_packet_q ? pkt_mode_q : mode;
  assign xform_s       = xform(eff_mode_s, s_axis_tdata);

  // Pipeline stages, mode latch, occupancy and counters.
  always_ff @(posedge clk) begin
    if (!aresetn) begin
      valid_q       <= '0;
      last_q        <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
      in_packet_q   <= 1'b0;
      pkt_mode_q    <= 2'd0;
      occ_q         <= '0;
      in_beats_q    <= '0;
      out_beats_q   <= '0;
      out_packets_q <= '0;
    end else begin
      for (int i = STAGES - 1; i > 0; i--) begin
        if (adv_s[i]) begin
          valid_q[i] <= valid_q[i-1];
          last_q[i]  <= last_q[i-1];
          data_q[i]  <= data_q[i-1];
        end
      end
      if (adv_s[0]) begin
        valid_q[0] <= accept_s;
        last_q[0]  <= s_axis_tlast;
        data_q[0]  <= xform_s;
      end
      if (accept_s) begin
        in_packet_q <= ~s_axis_tlast;
        in_beats_q  <= in_beats_q + COUNT_WIDTH'(1);
        if (!in_packet_q) begin
          pkt_mode_q <= mode;
        end
      end
      if (deliver_s) begin
        out_beats_q <= out_beats_q + COUNT_WIDTH'(1);
        if (last_q[STAGES-1]) begin
          out_packets_q <= out_packets_q + COUNT_WIDTH'(1);
        end
      end
      case ({accept_s, deliver_s})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign m_axis_tdata  = data_q[STAGES-1];
  assign m_axis_tlast  = last_q[STAGES-1];
  assign m_axis_tvalid = valid_q[STAGES-1];
  assign occupancy     = occ_q;
  assign in_beats      = in_beats_q;
  assign out_beats     = out_beats_q;
  assign out_packets   = out_packets_q;

endmodule

// File: doc/axis_xform_pipe.md
Name: axis_xform_pipe

Overview:
- Parametrised AXI4-Stream data-transform pipeline. Successor to the single-stage inverting squarer block.
- Generalised in three ways: data width, pipeline depth (STAGES), and a per-packet selectable transform mode.
- Adds in-flight occupancy and beat/packet counters so the formal harness can check conservation directly.
- Sits between an AXIS source and sink. Full throughput of one beat per cycle, with lossless backpressure.

Parameters:
- DATA_WIDTH, 32, tdata width. Even, >=2.
- STAGES, 2, number of register stages (1..8); latency in cycles.
- COUNT_WIDTH, 32, width of beat/packet counters. Counters wrap modulo 2^COUNT_WIDTH.

Ports:
- clk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- mode  in  2  transform select; sampled at packet start only
- s_axis_tdata  in  DATA_WIDTH  input data
- s_axis_tlast  in  1  input end-of-packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  DATA_WIDTH  output data
- m_axis_tlast  out  1  output end-of-packet
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- occupancy  out  $clog2(STAGES+1)  number of valid stages
- in_beats  out  COUNT_WIDTH  accepted input beats
- out_beats  out  COUNT_WIDTH  delivered output beats
- out_packets  out  COUNT_WIDTH  delivered beats with tlast=1

Behaviour:
- Reset: aresetn, synchronous, active-low; clock clk. While aresetn=0 on a rising edge, the following are cleared:
  - all stage valids, in_packet, pkt_mode (cleared to 0);
  - in_beats, out_beats, out_packets (cleared to 0);
  - m_axis_tdata and m_axis_tlast (cleared to 0).
- While aresetn=0, s_axis_tready=0 (combinational gate).
- Reset mid-operation discards in-flight beats. Counters restart at 0.
- Handshake:
  - Accept = s_axis_tvalid & s_axis_tready. Deliver = m_axis_tvalid & m_axis_tready.
  - Once m_axis_tvalid is asserted, it and m_axis_tdata/tlast hold stable until Deliver.
- Pipeline is elastic with bubble collapsing:
  - Stage i advances when stage i is empty or stage i+1 advances.
  - The last stage advances when it is empty or m_axis_tready=1.
  - s_axis_tready = advance of stage 0 (when aresetn=1).
  - The combinational ready path through all stages is accepted.
- Latency and throughput:
  - A beat accepted at edge t is presented on m_axis after edge t+STAGES-1, i.e. it becomes valid STAGES cycles after the accept cycle, provided there is no stall.
  - With tvalid and tready both held at 1, sustained throughput is 1 beat/cycle.
- Mode latch:
  - in_packet is set on Accept with tlast=0 and cleared on Accept with tlast=1.
  - On Accept when in_packet=0, the effective mode is the live `mode` input, and pkt_mode <= mode. Otherwise the effective mode is pkt_mode.
  - Mode changes mid-packet are ignored until the next packet's first beat.
- Transform (applied in stage 0; later stages are pure delay):
  - 0: pass-through.
  - 1: bitwise invert, ~tdata (legacy squarer behaviour).
  - 2: unsigned square of tdata[DATA_WIDTH/2-1:0], yielding a full DATA_WIDTH result with no overflow.
  - 3: two's-complement negate, modulo 2^DATA_WIDTH.
- tlast travels with its beat unchanged.
- occupancy: count of valid stages, updated each edge. Range 0..STAGES.
- Counters:
  - in_beats increments on Accept; out_beats increments on Deliver; out_packets increments on Deliver with tlast=1.
  - All counters wrap silently.
  - Invariant while aresetn=1: in_beats - out_beats == occupancy (mod 2^COUNT_WIDTH).
- Simultaneous Accept and Deliver in one cycle: occupancy unchanged, both counters increment.
- Full pipe (occupancy=STAGES) with m_axis_tready=0: s_axis_tready=0 and no state changes.
- Empty pipe: m_axis_tvalid=0.

Test Plan:
- Reset, STAGES=2, mode=1, tready held 1: send 0x00000000, 0x12345678 back-to-back -> m_axis shows 0xFFFFFFFF at cycle+2, then 0xEDCBA987. Counters read in=2, out=2, occupancy=0.
- mode=2, send 0xABCD0003 -> output 0x00000009. Send 0x0000FFFF -> output 0xFFFE0001.
- Mode latch: packet of 3 beats, mode=0 on beat 1, switched to 3 before beat 2, data 5 each -> outputs 5, 5, 5 (tlast on 3rd). Next packet, first beat 5 -> 0xFFFFFFFB.
- Backpressure: m_axis_tready=0, 5 beats offered, STAGES=2 -> 2 accepted, s_axis_tready=0, occupancy=2, m_axis_tdata stable. Release -> all 5 delivered in order, no loss or duplication.
- Reset mid-stream with occupancy=2 -> next cycle m_axis_tvalid=0, occupancy=0, counters 0, s_axis_tready=0 while aresetn=0.
- Wrap: COUNT_WIDTH=4, 17 beats streamed -> in_beats=1, out_beats=1, invariant holds each cycle.
